sensor_ultrassom_mc: RTL
========================

# sensor_ultrassom_mc

Multi-channel successor of the single-channel HC-SR04 ranging block: drives up to N ultrasonic sensors, either one selected channel per request or an automatic sweep of all channels. It generates each sensor's trigger pulse and times the echo pulse. It converts the echo width to centimetres with round-to-nearest and reports 3-digit BCD results tagged with the channel number, with an echo timeout. It sits between the top-level measurement controller and the sensor pins, replacing the per-sensor interface.

## Interface
- `N_CANAIS`, 4: number of sensor channels (1..2^CANAL_W).
- `CANAL_W`, 2: channel index width.
- `TRIGGER_CICLOS`, 500: trigger pulse length in clocks (10 us at 50 MHz).
- `CICLOS_CM`, 2941: clocks per centimetre (58.82 us at 50 MHz).
- `TIMEOUT_CICLOS`, 1_500_000: maximum wait for echo rise, and maximum echo width (30 ms).
- `PAUSA_CICLOS`, 50_000: gap between consecutive channels in sweep mode.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: reset, **asynchronous, active-low**.
- `medir` in 1: start request, level-sampled.
- `modo` in 1: request mode. 0 = single channel `canal_sel`; 1 = sweep channels 0..N_CANAIS-1.
- `canal_sel` in CANAL_W: channel for single mode.
- `echo` in N_CANAIS: asynchronous echo inputs.
- `trigger` out N_CANAIS: trigger pulses, one-hot or zero.
- `medida` out 12: distance in BCD (hundreds, tens, units).
- `canal` out CANAL_W: channel that produced `medida`.
- `pronto` out 1: one-cycle result strobe.
- `timeout` out 1: the last result timed out.
- `ocupado` out 1: high from request acceptance until the last result.
- `db_estado` out 4: current state code.

## Operation
- Each `echo` bit passes through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized signal of the active channel only.
- States and codes:
  - OCIOSO (0) -> PREPARA (1) when `medir`=1.
  - PREPARA (1): latch the channel (`canal_sel` in single mode, 0 in sweep mode), latch `modo`, clear counters. Always -> TRIGGER.
  - TRIGGER (2): `trigger[ch]`=1 for exactly TRIGGER_CICLOS cycles -> ESPERA_ECHO.
  - ESPERA_ECHO (3): on echo rise -> MEDE. After TIMEOUT_CICLOS cycles -> FIM with the timeout flag set.
  - MEDE (4): sub-counter counts 0..CICLOS_CM-1. Each wrap increments the 3-digit BCD counter, which saturates at 999. Echo fall -> CONVERTE. Width reaching TIMEOUT_CICLOS -> FIM with the timeout flag set.
  - CONVERTE (5): if sub-counter >= CICLOS_CM/2 (integer division), increment BCD, saturating at 999 -> FIM.
  - FIM (6): register `medida`, `canal`, `timeout`; pulse `pronto`. Then:
    - single mode, or last channel -> OCIOSO;
    - otherwise -> PAUSA.
  - PAUSA (7): wait PAUSA_CICLOS, channel+1 -> TRIGGER.
- On timeout, `medida` = 12'h999 and `timeout`=1. Otherwise `timeout`=0.
- `medir` is ignored outside OCIOSO, with no queuing.
- In single mode, `canal_sel` >= N_CANAIS is clamped to N_CANAIS-1.
- Echo activity on non-active channels is ignored.
- Reset at any time forces OCIOSO. Reset values: `trigger`=0, `medida`=0, `canal`=0, `pronto`=0, `timeout`=0, `ocupado`=0, `db_estado`=0. No partial result is reported.

## Timing
- `medir` sampled high at edge k: PREPARA at k+1, `trigger` rises at edge k+2 and stays high TRIGGER_CICLOS cycles. `ocupado`=1 from edge k+1.
- Echo edges are seen 2 cycles late (synchronizer). The counted width is the echo width ±1 clock.
- Echo fall at edge f (synchronized): CONVERTE at f+1, FIM at f+2, `pronto` high during cycle f+2..f+3.
- `medida`, `canal` and `timeout` change only in FIM and hold until the next FIM.
- `ocupado` drops with the last `pronto` (same edge).
- An echo already high when ESPERA_ECHO is entered is not a rise: the block waits for the next rising edge or times out.

## Test plan
- Single mode, channel 0, echo 5899 us after trigger + 20 us -> one `pronto`, `medida`=12'h100, `canal`=0, `timeout`=0.
- Single mode, channel 2, echo 4399 us, then 10000 us -> `medida`=12'h075 then 12'h170. Only `trigger[2]` ever pulses, each for 500 clocks.
- Sweep mode with N=4, echoes of 1000/2000/3000/4000 us -> four `pronto` strobes, `canal` 0,1,2,3, `medida` 017/034/051/068. Triggers are at least PAUSA_CICLOS apart. `ocupado` falls with the fourth strobe.
- Timeouts:
  - no echo on channel 1 -> `pronto` after 30 ms, `medida`=12'h999, `timeout`=1;
  - echo stuck high -> same result after 30 ms of width.
- `medir` pulsed again mid-measurement -> ignored, only one result. Echo on an inactive channel -> no effect.
- `reset` asserted low during MEDE -> outputs immediately at reset values, `db_estado`=0. A new `medir` after release measures correctly.

Source files
------------

// File: rtl/sensor_ultrassom_mc.sv
// Multi-channel HC-SR04 style ranging controller: per-channel trigger, echo timing,
// rounded conversion to 3-digit BCD centimetres, single-channel or sweep requests.
module sensor_ultrassom_mc #(
  parameter int N_CANAIS       = 4,
  parameter int CANAL_W        = 2,
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int TIMEOUT_CICLOS = 1_500_000,
  parameter int PAUSA_CICLOS   = 50_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                medir,
  input  logic                modo,
  input  logic [CANAL_W-1:0]  canal_sel,
  input  logic [N_CANAIS-1:0] echo,
  output logic [N_CANAIS-1:0] trigger,
  output logic [11:0]         medida,
  output logic [CANAL_W-1:0]  canal,
  output logic                pronto,
  output logic                timeout,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

  localparam int MAX_A = (TIMEOUT_CICLOS > PAUSA_CICLOS) ? TIMEOUT_CICLOS : PAUSA_CICLOS;
  localparam int MAX_C = (MAX_A > TRIGGER_CICLOS) ? MAX_A : TRIGGER_CICLOS;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int SUB_W = $clog2(CICLOS_CM + 1);

  localparam logic [CNT_W-1:0]   FIM_TRIG  = CNT_W'(TRIGGER_CICLOS - 1);
  localparam logic [CNT_W-1:0]   FIM_TMO   = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CNT_W-1:0]   FIM_PAUSA = CNT_W'(PAUSA_CICLOS - 1);
  localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(CICLOS_CM - 1);
  localparam logic [SUB_W-1:0]   SUB_HALF  = SUB_W'(CICLOS_CM / 2);
  localparam logic [CANAL_W:0]   N_EXT     = (CANAL_W + 1)'(N_CANAIS);
  localparam logic [CANAL_W-1:0] ULTIMO    = CANAL_W'(N_CANAIS - 1);
  localparam logic [11:0]        BCD_MAX   = 12'h999;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    PREPARA     = 3'd1,
    TRIGGER     = 3'd2,
    ESPERA_ECHO = 3'd3,
    MEDE        = 3'd4,
    CONVERTE    = 3'd5,
    FIM         = 3'd6,
    PAUSA       = 3'd7
  } estado_t;

  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] b);
    logic [11:0] r;
    if (b == BCD_MAX)          r = BCD_MAX;
    else if (b[3:0] != 4'd9)   r = {b[11:4], b[3:0] + 4'd1};
    else if (b[7:4] != 4'd9)   r = {b[11:8], b[7:4] + 4'd1, 4'd0};
    else                       r = {b[11:8] + 4'd1, 8'd0};
    return r;
  endfunction

  function automatic logic [11:0] bcd_round(input logic [11:0] b, input logic [SUB_W-1:0] resto);
    return (resto >= SUB_HALF) ? bcd_inc_sat(b) : b;
  endfunction

  estado_t               state, state_n;
  logic [CANAL_W-1:0]    ch, ch_n, canal_clamp;
  logic                  modo_r;
  logic [CNT_W-1:0]      cnt;
  logic [SUB_W-1:0]      sub;
  logic [11:0]           bcd;
  logic                  medir_p0;
  logic [N_CANAIS-1:0]   echo_p0, echo_p1;
  logic                  eco_prev, eco_ativo, sobe, desce;
  logic                  ultimo, tmo_ev;

  // Input stage: request register and 2-flop echo synchronizers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medir_p0 <= 1'b0;
      echo_p0  <= '0;
      echo_p1  <= '0;
      eco_prev <= 1'b0;
    end else begin
      medir_p0 <= medir;
      echo_p0  <= echo;
      echo_p1  <= echo_p0;
      eco_prev <= eco_ativo;
    end
  end

  // eco_prev follows the active channel continuously, so an echo already high
  // when ESPERA_ECHO is entered never looks like a rising edge.
  always_comb begin
    eco_ativo   = echo_p1[ch];
    sobe        = eco_ativo & ~eco_prev;
    desce       = ~eco_ativo & eco_prev;
    canal_clamp = ({1'b0, canal_sel} >= N_EXT) ? ULTIMO : canal_sel;
    ultimo      = !modo_r || (ch == ULTIMO);
    tmo_ev      = ((state == ESPERA_ECHO && !sobe) || (state == MEDE && !desce)) &&
                  (cnt == FIM_TMO);
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    case (state)
      OCIOSO:      if (medir_p0) state_n = PREPARA;
      PREPARA: begin
        state_n = TRIGGER;
        ch_n    = modo ? '0 : canal_clamp;
      end
      TRIGGER:     if (cnt == FIM_TRIG) state_n = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (sobe)                 state_n = MEDE;
        else if (cnt == FIM_TMO)  state_n = FIM;
      end
      MEDE: begin
        if (desce)                state_n = CONVERTE;
        else if (cnt == FIM_TMO)  state_n = FIM;
      end
      CONVERTE:    state_n = FIM;
      FIM:         state_n = ultimo ? OCIOSO : PAUSA;
      PAUSA: begin
        if (cnt == FIM_PAUSA) begin
          state_n = TRIGGER;
          ch_n    = ch + 1'b1;
        end
      end
      default:     state_n = OCIOSO;
    endcase
  end

  // Control stage: state, channel, shared phase counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= OCIOSO;
      ch     <= '0;
      modo_r <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      if (state == PREPARA) modo_r <= modo;
      if (state_n != state)
        cnt <= '0;
      else if (state inside {TRIGGER, ESPERA_ECHO, MEDE, PAUSA})
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Datapath stage: centimetre sub-counter and saturating BCD accumulator
  always_ff @(posedge clock) begin
    if (state == PREPARA || state == ESPERA_ECHO) begin
      sub <= '0;
      bcd <= '0;
    end else if (state == MEDE && !desce) begin
      if (sub == SUB_MAX) begin
        sub <= '0;
        bcd <= bcd_inc_sat(bcd);
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

  // Output stage: results load on FIM entry so they are valid with pronto
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigger <= '0;
      medida  <= '0;
      canal   <= '0;
      pronto  <= 1'b0;
      timeout <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      trigger <= (state_n == TRIGGER) ? (N_CANAIS'(1) << ch_n) : '0;
      pronto  <= (state_n == FIM);
      ocupado <= (state_n != OCIOSO) && !(state_n == FIM && ultimo);
      if (state_n == FIM) begin
        medida  <= tmo_ev ? BCD_MAX : bcd_round(bcd, sub);
        canal   <= ch;
        timeout <= tmo_ev;
      end
    end
  end

  assign db_estado = {1'b0, state};

endmodule
